wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/cpu_consts.sv | 14 +
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/cpu_consts.sv
// Shared CPU pipeline constants and the writeback entry type used by the
// register-file write arbiter.
package cpu_consts;

    localparam int WB_FIFO_DEPTH = 4;
    localparam int STARVE_LIMIT  = 8;
    localparam int MULT_LATENCY  = 5;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [63:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between the execute stage (multiplier + ALU) and the writeback arbiter.
// "master" is the execute-stage view, "slave" is the arbiter view.
interface wb_arbiter_if;

    logic        mult_issue_i;
    logic        mult_ready_o;

    logic        mult_valid_i;
    logic [4:0]  mult_rd_addr_i;
    logic        mult_rd_wr_en_i;
    logic [63:0] mult_res_i;

    logic        alu_valid_i;
    logic [4:0]  alu_rd_addr_i;
    logic        alu_rd_wr_en_i;
    logic [63:0] alu_res_i;
    logic        alu_stall_o;

    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [63:0] rf_wr_data_o;

    modport master (
        output mult_issue_i, mult_valid_i, mult_rd_addr_i, mult_rd_wr_en_i, mult_res_i,
        output alu_valid_i, alu_rd_addr_i, alu_rd_wr_en_i, alu_res_i,
        input  mult_ready_o, alu_stall_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o
    );

    modport slave (
        input  mult_issue_i, mult_valid_i, mult_rd_addr_i, mult_rd_wr_en_i, mult_res_i,
        input  alu_valid_i, alu_rd_addr_i, alu_rd_wr_en_i, alu_res_i,
        output mult_ready_o, alu_stall_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, generic in depth and entry type. The head entry is
// presented on pop_data whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop_en)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

    // NOTE: storage is deliberately not reset; a slot is only read after count
    // shows it was written, so clearing it would cost flops for nothing.
    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr] <= push_data;
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results have priority, buffered
// multiply results are forced through after STARVE_LIMIT-1 lost cycles.
module wb_arbiter #(
    parameter int WB_FIFO_DEPTH = cpu_consts::WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT  = cpu_consts::STARVE_LIMIT
) (
    input logic          clk,
    input logic          reset,
    wb_arbiter_if.slave  bus
);

    import cpu_consts::wb_entry_t;

    localparam int CW = $clog2(WB_FIFO_DEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    logic [CW-1:0] credit_q;
    logic [SW-1:0] starve_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    wb_entry_t     head;
    wb_entry_t     mult_entry;

    logic          mult_discard;
    logic          mult_push;
    logic          alu_grant;
    logic          head_grant;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mult_discard        = 1'b0;
        mult_push           = 1'b0;
        mult_entry.rd_addr  = bus.mult_rd_addr_i;
        mult_entry.data     = bus.mult_res_i;
        if (bus.mult_valid_i) begin
            mult_discard = !bus.mult_rd_wr_en_i || (bus.mult_rd_addr_i == '0);
            mult_push    = !mult_discard;
        end
    end

    // A starving head takes the port and stalls the ALU for this cycle.
    assign bus.alu_stall_o  = !fifo_empty && (starve_q == SW'(STARVE_LIMIT - 1));
    assign bus.mult_ready_o = (credit_q < CW'(WB_FIFO_DEPTH));
    assign alu_grant        = bus.alu_valid_i && !bus.alu_stall_o;
    assign head_grant       = !alu_grant && !fifo_empty;

    sync_fifo #(
        .DEPTH   (WB_FIFO_DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mult_push),
        .push_data (mult_entry),
        .pop       (head_grant),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q         <= '0;
            starve_q         <= '0;
            bus.rf_wr_en_o   <= 1'b0;
            bus.rf_wr_addr_o <= '0;
            bus.rf_wr_data_o <= '0;
        end else begin
            // Credits track in-flight multiplies plus buffered results.
            credit_q <= credit_q + CW'(bus.mult_issue_i) - CW'(head_grant) - CW'(mult_discard);

            if (fifo_empty || head_grant)
                starve_q <= '0;
            else
                starve_q <= starve_q + SW'(1);

            if (alu_grant) begin
                bus.rf_wr_en_o   <= bus.alu_rd_wr_en_i && (bus.alu_rd_addr_i != '0);
                bus.rf_wr_addr_o <= bus.alu_rd_addr_i;
                bus.rf_wr_data_o <= bus.alu_res_i;
            end else if (head_grant) begin
                bus.rf_wr_en_o   <= 1'b1;
                bus.rf_wr_addr_o <= head.rd_addr;
                bus.rf_wr_data_o <= head.data;
            end else begin
                bus.rf_wr_en_o   <= 1'b0;
            end
        end
    end

    a_issue_needs_credit: assert property (@(posedge clk) disable iff (reset)
        !(bus.mult_issue_i && !bus.mult_ready_o));
    a_credit_covers_fifo: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= credit_q);
    a_push_not_full:      assert property (@(posedge clk) disable iff (reset)
        !(mult_push && fifo_full));

endmodule
